// File: rtl/alu_serial.sv
// alu_serial: slice-serial integer ALU.
//
// Evaluates a WIDTH-bit AND/OR/XOR/ADD/SLT operation SLICE bits per clock,
// least-significant slice first, reusing one SLICE-bit ripple adder across
// N = WIDTH/SLICE cycles.
//
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous, active-high reset
//   start     - operation request, accepted only while busy=0
//   a, b      - WIDTH-bit operands, sampled on accept
//   ainv,binv - operand invert controls (binv also sets carry-in), sampled on accept
//   op        - 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SLT, others reserved
//   busy      - operation in progress
//   done      - one-cycle pulse when result/flags are updated
//   result    - result of the last completed operation
//   cout      - carry out of the MSB (ADD/SLT only)
//   overflow  - signed overflow (ADD/SLT only)
//   zero      - result == 0
module alu_serial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ainv,
  input  logic             binv,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  // Operand registers hold the already-inverted operands and are shifted
  // right by SLICE each RUN cycle, so the current slice is always at [SLICE-1:0].
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  // ---------------------------------------------------------------------
  // Slice datapath
  // ---------------------------------------------------------------------
  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_sum;
  logic [SLICE-1:0] slice_res;
  logic [SLICE:0]   chain;

  assign slice_a  = a_q[SLICE-1:0];
  assign slice_b  = b_q[SLICE-1:0];
  assign chain[0] = carry_q;

  genvar gi;
  generate
    for (gi = 0; gi < SLICE; gi++) begin : g_ripple
      assign slice_sum[gi] = slice_a[gi] ^ slice_b[gi] ^ chain[gi];
      assign chain[gi+1]   = (slice_a[gi] & slice_b[gi]) |
                             (chain[gi] & (slice_a[gi] ^ slice_b[gi]));
    end
  endgenerate

  always_comb begin
    slice_res = '0;
    case (op_q)
      OP_AND:         slice_res = slice_a & slice_b;
      OP_OR:          slice_res = slice_a | slice_b;
      OP_XOR:         slice_res = slice_a ^ slice_b;
      OP_ADD, OP_SLT: slice_res = slice_sum;
      default:        slice_res = '0;
    endcase
  end

  // Partial result fills from the top: after N cycles the first slice has
  // been shifted down to bit 0.
  logic [WIDTH-1:0] acc_next;
  assign acc_next = (acc_q >> SLICE) | (WIDTH'(slice_res) << (WIDTH - SLICE));

  // Flags from the final slice: the carry chain's last two taps are the
  // carries into and out of bit WIDTH-1.
  logic is_arith;
  logic c_out;
  logic c_in_msb;
  logic ovf_fin;
  logic [WIDTH-1:0] final_res;

  assign is_arith = (op_q == OP_ADD) || (op_q == OP_SLT);
  assign c_out    = chain[SLICE];
  assign c_in_msb = chain[SLICE-1];
  assign ovf_fin  = c_in_msb ^ c_out;

  always_comb begin
    final_res = '0;
    case (op_q)
      OP_AND, OP_OR, OP_XOR, OP_ADD: final_res = acc_next;
      // Sign of a-b corrected for overflow gives the true signed less-than.
      OP_SLT:  final_res = WIDTH'(acc_next[WIDTH-1] ^ ovf_fin);
      default: final_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Control: next-state and register updates
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    op_d       = op_q;
    carry_d    = carry_q;
    result_d   = result_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // SLT always computes a + ~b + 1 regardless of the invert controls.
          if (op == OP_SLT) begin
            a_d     = a;
            b_d     = ~b;
            carry_d = 1'b1;
          end else begin
            a_d     = ainv ? ~a : a;
            b_d     = binv ? ~b : b;
            carry_d = binv;
          end
          op_d    = op;
          acc_d   = '0;
          k_d     = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        carry_d = c_out;
        acc_d   = acc_next;
        k_d     = k_q + KW'(1);
        if (k_q == K_LAST) begin
          k_d        = '0;
          state_d    = S_IDLE;
          done_d     = 1'b1;
          result_d   = final_res;
          cout_d     = is_arith & c_out;
          overflow_d = is_arith & ovf_fin;
          zero_d     = (final_res == '0);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      op_q       <= '0;
      carry_q    <= 1'b0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      op_q       <= op_d;
      carry_q    <= carry_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = done_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule
